lcd_ctrl: RTL and testbench
===========================

// Module: lcd_ctrl
// PURPOSE
//  Consumes LCD register writes from the LSU (the LSU side of the LCD I/O path) and drives an HD44780-style
//  8-bit character LCD with correct setup/enable/hold/execute timing. Software issues one command/char per store;
//  block buffers one pending request and reports busy so firmware can poll instead of bit-banging delays.
// PARAMETERS
//  SETUP_CYC      2       cycles RS/DATA stable before EN rises
//  EN_HIGH_CYC    12      cycles EN held high (>=230 ns @50 MHz)
//  HOLD_CYC       2       cycles RS/DATA held after EN falls
//  EXEC_CYC       2000    post-transfer wait, normal command/char (40 us)
//  LONG_EXEC_CYC  82000   post-transfer wait for clear (0x01) / home (0x02|0x03) with RS=0 (1.64 ms)
//  POWERUP_CYC    750000  power-up wait before init sequence (15 ms); used only with LCD_INIT_EN
// PORTS
//  i_clk        in   1   clock
//  i_reset      in   1   synchronous, active-high reset
//  i_wr         in   1   1-cycle strobe: LSU store to LCD register
//  i_lcd_reg    in   32  [31]=ON, [9]=RS, [7:0]=DATA; other bits ignored
//  i_ovf_clr    in   1   clears o_ovf
//  o_lcd_data   out  8   LCD DB[7:0]
//  o_lcd_rs     out  1   LCD RS
//  o_lcd_rw     out  1   LCD RW, constant 0 (write-only)
//  o_lcd_en     out  1   LCD E
//  o_lcd_on     out  1   LCD power/backlight
//  o_busy       out  1   1 while FSM not IDLE or pending buffer valid
//  o_ovf        out  1   sticky: a write was dropped
// BEHAVIOUR
//  - One clock (i_clk); reset is synchronous and active-high (i_reset). All outputs registered except o_busy.
//  - Reset: data=0, rs=0, rw=0, en=0, on=0, ovf=0, pending invalid, counter=0;
//    state=POWERUP with LCD_INIT_EN, else IDLE. o_busy = (state!=IDLE)|pend_vld.
//  - States: IDLE -> SETUP(SETUP_CYC) -> PULSE(EN_HIGH_CYC, en=1) -> HOLD(HOLD_CYC) -> EXEC(EXEC_CYC or
//    LONG_EXEC_CYC) -> IDLE, or direct to SETUP if pending valid. Each state lasts exactly N cycles (counter
//    loads N-1, counts to 0). RS/DATA latched at SETUP entry and stable through HOLD.
//  - Accept: i_wr && IDLE && !pend_vld -> SETUP next cycle. Start-to-EN-rise = 1+SETUP_CYC cycles.
//  - i_wr while busy and pending empty -> stored in pending buffer.
//  - i_wr while pending full and not freed this cycle -> dropped, o_ovf=1 next cycle.
//  - Pending freed in same cycle as new i_wr (EXEC end) -> pending issued, new write takes the buffer; no drop.
//  - ovf set and i_ovf_clr same cycle -> set wins.
//  - o_lcd_on <= i_lcd_reg[31] on every i_wr (also dropped ones); it does not wait for the transfer.
//  - Long-exec select: RS=0 && DATA[7:2]==0 && DATA[1:0]!=0.
//  - i_reset mid-transfer: EN low next edge, transfer and pending discarded, FSM restarts per reset rule.
//  - Counter width = $clog2(max cycle param + 1); params >=1.
// CONFIGURATION
//  LCD_INIT_EN defined: after reset, POWERUP waits POWERUP_CYC, then INIT issues 0x38,0x0C,0x01,0x06 (RS=0)
//   through normal SETUP..EXEC timing, then IDLE. i_wr during init goes to pending (or is dropped if pending full).
//  LCD_INIT_EN undefined: reset enters IDLE; POWERUP/INIT states and init ROM absent; firmware must initialise.
// STRUCTURE
//  lcd_pkg: state enum (POWERUP, INIT, IDLE, SETUP, PULSE, HOLD, EXEC), register bit-position constants,
//   init command array and length, CMD_CLEAR/CMD_HOME constants.
//  Sub-module lcd_delay_cnt: loadable down-counter with done flag, shared by every timed state.
// TESTING (sim params: SETUP=2, EN_HIGH=3, HOLD=2, EXEC=5, LONG_EXEC=20, POWERUP=10)
//  1 No INIT_EN, reset then i_wr reg=0x8000_0241 -> on=1; en high 3 cyc, rs=1, data=0x41; busy for 12 cyc.
//  2 i_wr 0x01 (RS=0) -> EXEC lasts 20 cyc; i_wr 0x0200_0038 as RS=0 0x38 -> EXEC lasts 5.
//  3 Three back-to-back i_wr during busy -> first two transferred in order, third dropped, o_ovf=1;
//    i_ovf_clr -> 0.
//  4 i_wr on exact EXEC-last cycle with pending valid -> both written, no ovf.
//  5 i_reset asserted during PULSE -> en=0 next cycle, all outputs at reset values, pending lost.
//  6 LCD_INIT_EN: after reset busy=1, 10 cyc wait, four EN pulses carrying 0x38,0x0C,0x01,0x06,
//    then busy=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD controller.
// Defining LCD_INIT_EN adds the power-up init command table.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam int REG_ON_BIT = 31;
  localparam int REG_RS_BIT = 9;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

`ifdef LCD_INIT_EN
  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction
`endif

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) are the slow instructions on the panel.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed state of the LCD controller;
// a state loaded with N-1 lasts exactly N cycles.
module lcd_delay_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LSU-facing HD44780 write controller with a one-deep pending buffer.
// Define LCD_INIT_EN to run the power-up wait and init sequence after reset.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = 2,
  parameter int EN_HIGH_CYC   = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int POWERUP_CYC   = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [31:0] i_lcd_reg,
  input  logic        i_ovf_clr,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_ovf
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, EN_HIGH_CYC),
                                           max_int(HOLD_CYC, EXEC_CYC)),
                                   max_int(LONG_EXEC_CYC, POWERUP_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  lcd_state_e       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             on_q, on_d;
  logic             ovf_q, ovf_d;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             pend_rs_q, pend_rs_d;
  logic             issue_pend;
  logic             init_more;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic             unused_reg_bits;

  wire        wr_rs   = i_lcd_reg[REG_RS_BIT];
  wire [7:0]  wr_data = i_lcd_reg[7:0];

  assign unused_reg_bits = ^{i_lcd_reg[30:10], i_lcd_reg[8]};

`ifdef LCD_INIT_EN
  localparam lcd_state_e RST_STATE = POWERUP;
  logic [2:0] init_idx_q, init_idx_d;
  logic       pwr_arm_q, pwr_arm_d;

  assign init_more = (init_idx_q < 3'(INIT_LEN));
  // The counter resets to zero, so POWERUP spends its first cycle arming it.
  assign cnt_load  = (state_d != state_q) || ((state_q == POWERUP) && !pwr_arm_q);
`else
  localparam lcd_state_e RST_STATE = IDLE;

  assign init_more = 1'b0;
  assign cnt_load  = (state_d != state_q);
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rs_d        = rs_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_rs_d   = pend_rs_q;
    ovf_d       = ovf_q & ~i_ovf_clr;
    on_d        = i_wr ? i_lcd_reg[REG_ON_BIT] : on_q;
    issue_pend  = 1'b0;
`ifdef LCD_INIT_EN
    init_idx_d  = init_idx_q;
    pwr_arm_d   = pwr_arm_q;
`endif

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          state_d    = SETUP;
          data_d     = pend_data_q;
          rs_d       = pend_rs_q;
          issue_pend = 1'b1;
        end else if (i_wr) begin
          state_d = SETUP;
          data_d  = wr_data;
          rs_d    = wr_rs;
        end
      end
      SETUP: if (cnt_done) state_d = PULSE;
      PULSE: if (cnt_done) state_d = HOLD;
      HOLD:  if (cnt_done) state_d = EXEC;
      EXEC: begin
        if (cnt_done) begin
          if (init_more) begin
            state_d = INIT;
          end else if (pend_vld_q) begin
            state_d    = SETUP;
            data_d     = pend_data_q;
            rs_d       = pend_rs_q;
            issue_pend = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef LCD_INIT_EN
      POWERUP: begin
        pwr_arm_d = 1'b1;
        if (pwr_arm_q && cnt_done) state_d = INIT;
      end
      INIT: begin
        state_d    = SETUP;
        data_d     = init_cmd(init_idx_q);
        rs_d       = 1'b0;
        init_idx_d = init_idx_q + 3'd1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A buffer being issued this cycle is free for the incoming write.
    if (i_wr && !((state_q == IDLE) && !pend_vld_q)) begin
      if (!pend_vld_q || issue_pend) begin
        pend_vld_d  = 1'b1;
        pend_data_d = wr_data;
        pend_rs_d   = wr_rs;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (issue_pend) begin
      pend_vld_d = 1'b0;
    end

    en_d = (state_d == PULSE);
  end

  always_comb begin
    cnt_val = '0;
    case (state_d)
      SETUP:   cnt_val = CNT_W'(SETUP_CYC - 1);
      PULSE:   cnt_val = CNT_W'(EN_HIGH_CYC - 1);
      HOLD:    cnt_val = CNT_W'(HOLD_CYC - 1);
      EXEC:    cnt_val = is_long_cmd(rs_q, data_q) ? CNT_W'(LONG_EXEC_CYC - 1)
                                                   : CNT_W'(EXEC_CYC - 1);
      POWERUP: cnt_val = CNT_W'(POWERUP_CYC - 1);
      default: cnt_val = '0;
    endcase
  end

  lcd_delay_cnt #(.W(CNT_W)) u_delay (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .o_done     (cnt_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= RST_STATE;
      data_q      <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      ovf_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_rs_q   <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx_q  <= '0;
      pwr_arm_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      on_q        <= on_d;
      ovf_q       <= ovf_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_rs_q   <= pend_rs_d;
`ifdef LCD_INIT_EN
      init_idx_q  <= init_idx_d;
      pwr_arm_q   <= pwr_arm_d;
`endif
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_ovf      = ovf_q;
  assign o_busy     = (state_q != IDLE) || pend_vld_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl using short simulation timing
// (SETUP=2, EN_HIGH=3, HOLD=2, EXEC=5, LONG_EXEC=20, POWERUP=10).
module tb_lcd_ctrl;

  localparam int GUARD = 2000;

`ifdef LCD_INIT_EN
  localparam logic BUSY_AFTER_RESET = 1'b1;
  localparam int   PULSES_AFTER_RESET = 4;
`else
  localparam logic BUSY_AFTER_RESET = 1'b0;
  localparam int   PULSES_AFTER_RESET = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [31:0] lcd_reg;
  logic        ovf_clr;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic        o_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .SETUP_CYC     (2),
    .EN_HIGH_CYC   (3),
    .HOLD_CYC      (2),
    .EXEC_CYC      (5),
    .LONG_EXEC_CYC (20),
    .POWERUP_CYC   (10)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_wr       (wr),
    .i_lcd_reg  (lcd_reg),
    .i_ovf_clr  (ovf_clr),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on),
    .o_busy     (o_busy),
    .o_ovf      (o_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [31:0] r, input logic c);
    wr      = w;
    lcd_reg = r;
    ovf_clr = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag, input logic busy_exp);
    checkOutput({tag, "_data"}, 32'(o_lcd_data), 32'h0);
    checkOutput({tag, "_rs"},   32'(o_lcd_rs),   32'h0);
    checkOutput({tag, "_rw"},   32'(o_lcd_rw),   32'h0);
    checkOutput({tag, "_en"},   32'(o_lcd_en),   32'h0);
    checkOutput({tag, "_on"},   32'(o_lcd_on),   32'h0);
    checkOutput({tag, "_ovf"},  32'(o_ovf),      32'h0);
    checkOutput({tag, "_busy"}, 32'(o_busy),     32'(busy_exp));
  endtask

  // Starting on the first cycle after an accepted write, times one complete transfer.
  task automatic measureXfer(output int pre, output int en_len, output int busy_len,
                             output logic [7:0] d, output logic r, output logic ok);
    int g;
    g = 0; pre = 0; en_len = 0; busy_len = 0; d = '0; r = 1'b0;
    while (!o_lcd_en && g < GUARD) begin pre++; busy_len++; tick(); g++; end
    d = o_lcd_data;
    r = o_lcd_rs;
    while (o_lcd_en && g < GUARD) begin en_len++; busy_len++; tick(); g++; end
    while (o_busy && g < GUARD) begin busy_len++; tick(); g++; end
    ok = (g < GUARD);
  endtask

  task automatic nextPulse(output logic [7:0] d, output logic r, output logic ok);
    int g;
    g = 0; d = '0; r = 1'b0; ok = 1'b0;
    while (!o_lcd_en && g < GUARD) begin tick(); g++; end
    if (o_lcd_en) begin
      d  = o_lcd_data;
      r  = o_lcd_rs;
      ok = 1'b1;
    end
    while (o_lcd_en && g < GUARD) begin tick(); g++; end
  endtask

  task automatic waitIdle(output int pulses, output logic ok);
    int   g;
    logic prev;
    g = 0; pulses = 0; prev = o_lcd_en;
    while (o_busy && g < GUARD) begin
      tick(); g++;
      if (o_lcd_en && !prev) pulses++;
      prev = o_lcd_en;
    end
    ok = !o_busy;
  endtask

  task automatic countPulses(input int n, output int pulses);
    logic prev;
    pulses = 0; prev = o_lcd_en;
    for (int i = 0; i < n; i++) begin
      tick();
      if (o_lcd_en && !prev) pulses++;
      prev = o_lcd_en;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int         pre, en_len, busy_len, pulses;
    logic [7:0] d;
    logic       r, ok;

    applyStimulus(1'b0, 32'h0, 1'b0);
    doReset();
    checkResetState("reset", BUSY_AFTER_RESET);

`ifdef LCD_INIT_EN
    nextPulse(d, r, ok); checkOutput("init0_data", 32'(d), 32'h38); checkOutput("init0_rs", 32'(r), 32'h0);
    nextPulse(d, r, ok); checkOutput("init1_data", 32'(d), 32'h0C);
    nextPulse(d, r, ok); checkOutput("init2_data", 32'(d), 32'h01);
    nextPulse(d, r, ok); checkOutput("init3_data", 32'(d), 32'h06); checkOutput("init3_ok", 32'(ok), 32'h1);
    waitIdle(pulses, ok);
    checkOutput("init_idle", 32'(ok), 32'h1);
    checkOutput("init_extra_pulses", 32'(pulses), 32'h0);
`endif

    // Character write with RS=1 and panel power on.
    applyStimulus(1'b1, 32'h8000_0241, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_on", 32'(o_lcd_on), 32'h1);
    checkOutput("t1_busy", 32'(o_busy), 32'h1);
    measureXfer(pre, en_len, busy_len, d, r, ok);
    checkOutput("t1_setup_len", 32'(pre), 32'd2);
    checkOutput("t1_en_len", 32'(en_len), 32'd3);
    checkOutput("t1_busy_len", 32'(busy_len), 32'd12);
    checkOutput("t1_data", 32'(d), 32'h41);
    checkOutput("t1_rs", 32'(r), 32'h1);
    checkOutput("t1_done", 32'(ok), 32'h1);

    // Long-exec selection boundaries.
    applyStimulus(1'b1, 32'h0000_0001, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t2_clear_on", 32'(o_lcd_on), 32'h0);
    measureXfer(pre, en_len, busy_len, d, r, ok);
    checkOutput("t2_clear_busy", 32'(busy_len), 32'd27);
    checkOutput("t2_clear_rs", 32'(r), 32'h0);

    applyStimulus(1'b1, 32'h0200_0038, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    measureXfer(pre, en_len, busy_len, d, r, ok);
    checkOutput("t2_func_busy", 32'(busy_len), 32'd12);
    checkOutput("t2_func_data", 32'(d), 32'h38);
    checkOutput("t2_func_rs", 32'(r), 32'h0);

    applyStimulus(1'b1, 32'h0000_0003, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    measureXfer(pre, en_len, busy_len, d, r, ok);
    checkOutput("t2_home3_busy", 32'(busy_len), 32'd27);

    applyStimulus(1'b1, 32'h0000_0201, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    measureXfer(pre, en_len, busy_len, d, r, ok);
    checkOutput("t2_rs1_01_busy", 32'(busy_len), 32'd12);

    applyStimulus(1'b1, 32'h0000_0004, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    measureXfer(pre, en_len, busy_len, d, r, ok);
    checkOutput("t2_cmd04_busy", 32'(busy_len), 32'd12);

    // Back-to-back writes: third is dropped; a drop with clear in the same cycle keeps ovf set.
    applyStimulus(1'b1, 32'h8000_0211, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0222, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0233, 1'b0);
    tick();
    checkOutput("t3_ovf_set", 32'(o_ovf), 32'h1);
    applyStimulus(1'b1, 32'h0000_0244, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_ovf_set_wins", 32'(o_ovf), 32'h1);
    checkOutput("t3_on_dropped", 32'(o_lcd_on), 32'h0);
    nextPulse(d, r, ok);
    checkOutput("t3_first_data", 32'(d), 32'h11);
    nextPulse(d, r, ok);
    checkOutput("t3_second_data", 32'(d), 32'h22);
    checkOutput("t3_second_rs", 32'(r), 32'h1);
    waitIdle(pulses, ok);
    checkOutput("t3_no_third", 32'(pulses), 32'h0);
    checkOutput("t3_idle", 32'(ok), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_ovf_cleared", 32'(o_ovf), 32'h0);

    // Write lands on the last EXEC cycle while the buffer is full.
    applyStimulus(1'b1, 32'h8000_0250, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0251, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t4_a_en", 32'(o_lcd_en), 32'h1);
    checkOutput("t4_a_data", 32'(o_lcd_data), 32'h50);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("t4_exec_last_busy", 32'(o_busy), 32'h1);
    applyStimulus(1'b1, 32'h8000_0252, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_no_ovf", 32'(o_ovf), 32'h0);
    nextPulse(d, r, ok);
    checkOutput("t4_b_data", 32'(d), 32'h51);
    nextPulse(d, r, ok);
    checkOutput("t4_c_data", 32'(d), 32'h52);
    waitIdle(pulses, ok);
    checkOutput("t4_extra_pulses", 32'(pulses), 32'h0);
    checkOutput("t4_ovf_end", 32'(o_ovf), 32'h0);

    // Reset in the middle of the enable pulse with a pending write.
    applyStimulus(1'b1, 32'h8000_0255, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8000_0266, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t5_en_before", 32'(o_lcd_en), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkResetState("t5_reset", BUSY_AFTER_RESET);
    countPulses(150, pulses);
    checkOutput("t5_pending_lost", 32'(pulses), 32'(PULSES_AFTER_RESET));
    checkOutput("t5_final_busy", 32'(o_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
